// File: rtl/gray_conv_arbiter_pkg.sv
// Shared definitions for the two-requester Gray conversion arbiter.
package gray_conv_arbiter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // Requester identity carried alongside each result.
  typedef enum logic {
    ID_REQ0 = 1'b0,
    ID_REQ1 = 1'b1
  } req_id_e;

  // Output stage occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// Request/response bundle between the producers, the arbiter and the consumer.
interface gray_conv_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_bin;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_bin;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_gray;
  logic             out_id;
  logic             out_ready;
  logic [CNT_W-1:0] acc_cnt0;
  logic [CNT_W-1:0] acc_cnt1;

  // Environment side: producers plus consumer.
  modport master (
    output req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
    input  req0_ready, req1_ready, out_valid, out_gray, out_id, acc_cnt0, acc_cnt1
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
    output req0_ready, req1_ready, out_valid, out_gray, out_id, acc_cnt0, acc_cnt1
  );
endinterface

// File: rtl/gray_conv_arbiter_binary_to_gray.sv
// Purely combinational binary to reflected-Gray converter.
module binary_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  // Each Gray bit is the XOR of adjacent binary bits.
  always_comb begin
    gray = bin ^ (bin >> 1);
  end
endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin sharing of one binary_to_gray converter between two requesters,
// with a single registered output entry tagged by requester ID.
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  gray_conv_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  req_id_e          id_q, id_d;
  req_id_e          last_q, last_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             can_accept;
  logic             gnt_vld;
  req_id_e          gnt_id;
  logic             xfer;
  logic [WIDTH-1:0] mux_bin;
  logic [WIDTH-1:0] conv_gray;

  // Grant selection: a lone requester wins; a tie goes to whoever did not win last.
  always_comb begin
    can_accept = (state_q == EMPTY) || bus.out_ready;
    gnt_vld    = 1'b0;
    gnt_id     = ID_REQ0;
    unique case ({bus.req1_valid, bus.req0_valid})
      2'b01: begin gnt_vld = 1'b1; gnt_id = ID_REQ0; end
      2'b10: begin gnt_vld = 1'b1; gnt_id = ID_REQ1; end
      2'b11: begin
        gnt_vld = 1'b1;
        gnt_id  = (last_q == ID_REQ0) ? ID_REQ1 : ID_REQ0;
      end
      default: begin gnt_vld = 1'b0; gnt_id = ID_REQ0; end
    endcase
    xfer           = can_accept && gnt_vld && !rst;
    bus.req0_ready = xfer && (gnt_id == ID_REQ0);
    bus.req1_ready = xfer && (gnt_id == ID_REQ1);
    mux_bin        = (gnt_id == ID_REQ1) ? bus.req1_bin : bus.req0_bin;
  end

  binary_to_gray #(.WIDTH(WIDTH)) u_b2g (
    .bin  (mux_bin),
    .gray (conv_gray)
  );

  // Next-state: load on transfer (including drain+load in FULL), empty on pure drain.
  always_comb begin
    state_d = state_q;
    gray_d  = gray_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    unique case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL: begin
        if (xfer)               state_d = FULL;
        else if (bus.out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (xfer) begin
      gray_d = conv_gray;
      id_d   = gnt_id;
      last_d = gnt_id;
      if (gnt_id == ID_REQ0) begin
        if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
      end else begin
        if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
      end
    end
  end

  // State register; reset biases the first tie toward requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      gray_q  <= '0;
      id_q    <= ID_REQ0;
      last_q  <= ID_REQ1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      gray_q  <= gray_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_gray  = gray_q;
  assign bus.out_id    = id_q;
  assign bus.acc_cnt0  = cnt0_q;
  assign bus.acc_cnt1  = cnt1_q;

endmodule
